// File: rtl/matrix_mult_pkg.sv
// Shared types and elaboration-time helpers for the streaming matrix multiplier.
package matrix_mult_pkg;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

  // Result width that cannot overflow for N products of DATA_W-bit operands.
  function automatic int acc_width(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

  function automatic int beat_count(input int n, input int lanes);
    return (n * n) / lanes;
  endfunction

  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate column lane: extends both operands to ACC_W and
// accumulates; clear starts a new dot product with the current product.
module mac_lane
  import matrix_mult_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc_out
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;
  logic [ACC_W-1:0] product;

  assign a_ext   = signed_mode ? {{(ACC_W-DATA_W){a[DATA_W-1]}}, a} : {{(ACC_W-DATA_W){1'b0}}, a};
  assign b_ext   = signed_mode ? {{(ACC_W-DATA_W){b[DATA_W-1]}}, b} : {{(ACC_W-DATA_W){1'b0}}, b};
  // Truncating an ACC_W x ACC_W product to ACC_W is exact in two's complement.
  assign product = a_ext * b_ext;
  assign acc_out = clear ? product : acc + product;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_out;
    end
  end

endmodule

// File: rtl/matrix_mult_stream.sv
// Streaming N x N matrix multiplier: load A then B, compute one C row per N
// cycles on N MAC lanes, then drain C row-major over a valid/ready stream.
module matrix_mult_stream
  import matrix_mult_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int LANES  = 4,
  parameter int ACC_W  = acc_width(DATA_W, N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    signed_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ACC_W-1:0]  out_data,
  output logic                    busy,
  output logic                    done
);

  localparam int BEATS = beat_count(N, LANES);
  localparam int CNT_W = cnt_width(BEATS);
  localparam int IDX_W = cnt_width(N * N);
  localparam int RC_W  = cnt_width(N);

  if (N < 2 || (N % LANES) != 0) begin : g_param_check
    $error("matrix_mult_stream: N must be >= 2 and a multiple of LANES");
  end

  state_t state, state_next;

  logic [CNT_W-1:0]  load_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [RC_W-1:0]   row_i;
  logic [RC_W-1:0]   col_k;
  logic              sign_q;

  logic [DATA_W-1:0] a_mem [N*N];
  logic [DATA_W-1:0] b_mem [N*N];
  logic [ACC_W-1:0]  c_mem [N*N];

  logic [DATA_W-1:0] lane_a;
  logic [DATA_W-1:0] lane_b   [N];
  logic [ACC_W-1:0]  lane_sum [N];

  logic in_fire, out_fire, load_last, out_last, k_first, k_last, i_last, computing;

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid = (state == DRAIN);
  assign busy      = (state == COMPUTE) || (state == DRAIN);
  assign computing = (state == COMPUTE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign load_last = (load_cnt == CNT_W'(BEATS - 1));
  assign out_last  = (out_cnt == CNT_W'(BEATS - 1));
  assign k_first   = (col_k == '0);
  assign k_last    = (col_k == RC_W'(N - 1));
  assign i_last    = (row_i == RC_W'(N - 1));
  assign done      = out_fire && out_last && !reset;

  // NOTE: next state gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      LOAD_A:  if (in_valid && load_last) state_next = LOAD_B;
      LOAD_B:  if (in_valid && load_last) state_next = COMPUTE;
      COMPUTE: if (k_last && i_last)      state_next = DRAIN;
      DRAIN:   if (out_ready && out_last) state_next = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD_A;
      load_cnt <= '0;
      out_cnt  <= '0;
      row_i    <= '0;
      col_k    <= '0;
      sign_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (in_fire) begin
        load_cnt <= load_last ? '0 : load_cnt + 1'b1;
      end
      if (in_fire && (state == LOAD_A) && (load_cnt == '0)) begin
        sign_q <= signed_mode;
      end
      if (computing) begin
        col_k <= k_last ? '0 : col_k + 1'b1;
        if (k_last) begin
          row_i <= i_last ? '0 : row_i + 1'b1;
        end
      end
      if (out_fire) begin
        out_cnt <= out_last ? '0 : out_cnt + 1'b1;
      end
    end
  end

  // NOTE: storage arrays carry no reset; each element is written before it is read.
  always_ff @(posedge clk) begin
    if (in_fire && !reset) begin
      for (int l = 0; l < LANES; l++) begin
        if (state == LOAD_A) begin
          a_mem[IDX_W'(int'(load_cnt) * LANES + l)] <= in_data[l*DATA_W +: DATA_W];
        end else begin
          b_mem[IDX_W'(int'(load_cnt) * LANES + l)] <= in_data[l*DATA_W +: DATA_W];
        end
      end
    end
    if (computing && k_last && !reset) begin
      for (int j = 0; j < N; j++) begin
        c_mem[IDX_W'(int'(row_i) * N + j)] <= lane_sum[j];
      end
    end
  end

  assign lane_a = a_mem[IDX_W'(int'(row_i) * N + int'(col_k))];

  for (genvar j = 0; j < N; j++) begin : g_lane
    assign lane_b[j] = b_mem[IDX_W'(int'(col_k) * N + j)];

    mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_mac_lane (
      .clk         (clk),
      .reset       (reset),
      .clear       (k_first),
      .en          (computing),
      .signed_mode (sign_q),
      .a           (lane_a),
      .b           (lane_b[j]),
      .acc_out     (lane_sum[j])
    );
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int l = 0; l < LANES; l++) begin
        out_data[l*ACC_W +: ACC_W] = c_mem[IDX_W'(int'(out_cnt) * LANES + l)];
      end
    end
  end

endmodule

// File: tb/tb_matrix_mult_stream.sv
// Bench for matrix_mult_stream: a 4x4/4-lane and a 2x2/1-lane instance driven
// with directed and random matrices and checked against an arithmetic model.
module tb_matrix_mult_stream;

  typedef struct {
    longint v [4];
    bit     last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        signed_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = '0;

  logic        in_ready0, out_valid0, busy0, done0;
  logic [71:0] out_data0;
  logic        in_ready1, out_valid1, busy1, done1;
  logic [16:0] out_data1;

  logic   cur_in_ready, cur_out_valid, cur_busy, cur_done;
  longint got [4];

  int     n_checks = 0;
  int     n_fail = 0;
  int     cur_n = 4;
  int     cur_lanes = 4;
  int     cur_accw = 18;
  int     mat_a [16];
  int     mat_b [16];
  beat_t  exp_q [$];
  longint got_log [$];
  int     beats_acc = 0;
  int     stall_left = 0;
  bit     rand_ready = 1'b0;

  matrix_mult_stream #(.DATA_W(8), .N(4), .LANES(4)) dut0 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid && !sel),
    .in_ready    (in_ready0),
    .in_data     (in_data),
    .signed_mode (signed_mode),
    .out_valid   (out_valid0),
    .out_ready   (out_ready && !sel),
    .out_data    (out_data0),
    .busy        (busy0),
    .done        (done0)
  );

  matrix_mult_stream #(.DATA_W(8), .N(2), .LANES(1)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid && sel),
    .in_ready    (in_ready1),
    .in_data     (in_data[7:0]),
    .signed_mode (signed_mode),
    .out_valid   (out_valid1),
    .out_ready   (out_ready && sel),
    .out_data    (out_data1),
    .busy        (busy1),
    .done        (done1)
  );

  always #5 clk = ~clk;

  assign cur_in_ready  = sel ? in_ready1  : in_ready0;
  assign cur_out_valid = sel ? out_valid1 : out_valid0;
  assign cur_busy      = sel ? busy1      : busy0;
  assign cur_done      = sel ? done1      : done0;

  always_comb begin
    for (int l = 0; l < 4; l++) got[l] = 0;
    if (!sel) begin
      for (int l = 0; l < 4; l++) got[l] = longint'(out_data0[l*18 +: 18]);
    end else begin
      got[0] = longint'(out_data1);
    end
  end

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic longint ext(input int x, input bit sm);
    return (sm && x >= 128) ? longint'(x - 256) : longint'(x);
  endfunction

  // Reference: C = A*B with plain integer arithmetic, reduced to the result width.
  task automatic push_expected(input bit sm);
    longint c [16];
    longint mask;
    beat_t  bt;
    int     beats;
    mask  = (longint'(1) <<< cur_accw) - 1;
    beats = cur_n * cur_n / cur_lanes;
    for (int i = 0; i < cur_n; i++) begin
      for (int j = 0; j < cur_n; j++) begin
        c[i*cur_n + j] = 0;
        for (int k = 0; k < cur_n; k++) begin
          c[i*cur_n + j] += ext(mat_a[i*cur_n + k], sm) * ext(mat_b[k*cur_n + j], sm);
        end
      end
    end
    for (int b = 0; b < beats; b++) begin
      bt.last = (b == beats - 1);
      for (int l = 0; l < 4; l++) bt.v[l] = (l < cur_lanes) ? (c[b*cur_lanes + l] & mask) : 0;
      exp_q.push_back(bt);
    end
  endtask

  // Called and returns just after a falling edge.
  task automatic send_beat(input logic [31:0] d);
    int g = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!cur_in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("in_ready_timeout", longint'(cur_in_ready), 1);
    @(negedge clk);
  endtask

  task automatic load_pair(input bit sm, input bit gaps, input bit toggle);
    int          beats;
    logic [31:0] d;
    beats       = cur_n * cur_n / cur_lanes;
    signed_mode = sm;
    for (int ph = 0; ph < 2; ph++) begin
      for (int b = 0; b < beats; b++) begin
        if (gaps) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        d = '0;
        for (int l = 0; l < cur_lanes; l++) begin
          d[l*8 +: 8] = (ph == 0) ? 8'(mat_a[b*cur_lanes + l]) : 8'(mat_b[b*cur_lanes + l]);
        end
        send_beat(d);
        if (toggle) signed_mode = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (!cur_done && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check({name, "_done_seen"}, longint'(cur_done), 1);
    @(negedge clk);
    check({name, "_after_done_out_valid"}, longint'(cur_out_valid), 0);
    check({name, "_after_done_in_ready"}, longint'(cur_in_ready), 1);
  endtask

  task automatic run_matrix(input string name, input bit sm, input bit gaps, input bit toggle,
                            input bit stall);
    int lat = 0;
    got_log.delete();
    beats_acc = 0;
    push_expected(sm);
    load_pair(sm, gaps, toggle);
    // Junk input while the block is busy must not be consumed.
    in_valid = 1'b1;
    in_data  = $urandom;
    check({name, "_busy_in_compute"}, longint'(cur_busy), 1);
    check({name, "_in_ready_in_compute"}, longint'(cur_in_ready), 0);
    while (!cur_out_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, cur_n * cur_n);
    if (stall) begin
      @(posedge clk);
      stall_left = 5;
      @(negedge clk);
    end
    wait_done(name);
    in_valid = 1'b0;
    check({name, "_beats_accepted"}, beats_acc, cur_n * cur_n / cur_lanes);
  endtask

  task automatic check_log(input string name, input longint vals [16], input int count);
    check({name, "_log_size"}, got_log.size(), count);
    for (int i = 0; i < count && i < got_log.size(); i++) check(name, got_log[i], vals[i]);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = $urandom_range(0, 255);
      mat_b[i] = $urandom_range(0, 255);
    end
  endtask

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin : monitor
    bit exp_done;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_done = 1'b0;
        if (exp_q.size() == 0) begin
          check("out_valid_without_result", longint'(cur_out_valid), 0);
        end else if (cur_out_valid) begin
          for (int l = 0; l < cur_lanes; l++) check("c_element", got[l], exp_q[0].v[l]);
          if (out_ready) begin
            exp_done = exp_q[0].last;
            for (int l = 0; l < cur_lanes; l++) got_log.push_back(got[l]);
            beats_acc++;
            exp_q.delete(0);
          end
        end
        check("done_pulse", longint'(cur_done), longint'(exp_done));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "time limit reached");
  end

  initial begin : main
    longint lits [16];
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", longint'(in_ready0), 1);
    check("reset_out_valid", longint'(out_valid0), 0);
    check("reset_out_data_zero", longint'(out_data0 != '0), 0);
    check("reset_busy", longint'(busy0), 0);
    check("reset_done", longint'(done0), 0);
    check("reset_in_ready_n2", longint'(in_ready1), 1);
    check("reset_out_valid_n2", longint'(out_valid1), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Identity times B reproduces B.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mat_a[r*4 + c] = (r == c) ? 1 : 0;
        mat_b[r*4 + c] = 4*r + c;
        lits[r*4 + c]  = 4*r + c;
      end
    end
    run_matrix("identity", 1'b0, 1'b0, 1'b0, 1'b0);
    check_log("identity_c", lits, 16);

    // Unsigned maximum operands: 4 * 255 * 255.
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = 255;
      mat_b[i] = 255;
      lits[i]  = 260100;
    end
    run_matrix("unsigned_max", 1'b0, 1'b0, 1'b0, 1'b0);
    check_log("unsigned_max_c", lits, 16);

    // Signed extremes with signed_mode wiggling after the first A beat.
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = 128;
      mat_b[i] = 128;
      lits[i]  = 65536;
    end
    run_matrix("signed_min_min", 1'b1, 1'b0, 1'b1, 1'b0);
    check_log("signed_min_min_c", lits, 16);
    for (int i = 0; i < 16; i++) begin
      mat_b[i] = 127;
      lits[i]  = 197120;  // -65024 as an 18-bit pattern
    end
    run_matrix("signed_min_max", 1'b1, 1'b0, 1'b1, 1'b0);
    check_log("signed_min_max_c", lits, 16);

    // Random operands with input gaps and random output backpressure.
    rand_ready = 1'b1;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      run_matrix("random_gaps", 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
    end
    rand_ready = 1'b0;
    @(negedge clk);

    // Five-cycle stall after the first output beat.
    fill_random();
    run_matrix("drain_stall", 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of COMPUTE: nothing is produced, state returns to idle.
    fill_random();
    got_log.delete();
    load_pair(1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_in_ready", longint'(in_ready0), 1);
    check("midreset_out_valid", longint'(out_valid0), 0);
    check("midreset_busy", longint'(busy0), 0);
    check("midreset_done", longint'(done0), 0);
    repeat (30) @(negedge clk);

    // Fresh run after the abort: I * 2I = 2I.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mat_a[r*4 + c] = (r == c) ? 1 : 0;
        mat_b[r*4 + c] = (r == c) ? 2 : 0;
        lits[r*4 + c]  = (r == c) ? 2 : 0;
      end
    end
    run_matrix("after_reset_2i", 1'b0, 1'b0, 1'b0, 1'b0);
    check_log("after_reset_2i_c", lits, 16);

    // 2x2 instance, one element per beat, then a back-to-back second matrix.
    sel       = 1'b1;
    cur_n     = 2;
    cur_lanes = 1;
    cur_accw  = 17;
    @(negedge clk);
    mat_a[0] = 1; mat_a[1] = 2; mat_a[2] = 3; mat_a[3] = 4;
    mat_b[0] = 5; mat_b[1] = 6; mat_b[2] = 7; mat_b[3] = 8;
    lits[0] = 19; lits[1] = 22; lits[2] = 43; lits[3] = 50;
    run_matrix("n2_small", 1'b0, 1'b0, 1'b0, 1'b0);
    check_log("n2_small_c", lits, 4);
    fill_random();
    run_matrix("n2_back_to_back", 1'b1, 1'b0, 1'b1, 1'b0);
    fill_random();
    rand_ready = 1'b1;
    run_matrix("n2_random", 1'b0, 1'b1, 1'b1, 1'b0);
    rand_ready = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_mult_stream.md
Name: matrix_mult_stream

Overview:
- Parametrised N×N integer matrix multiplier computing C = A·B.
- Operands are loaded over a valid/ready input stream. The product is computed with N parallel MAC lanes, one output row per N cycles. C is drained over a valid/ready output stream.
- Successor to the fixed 4×4, 8-bit, single-shot multiplier. Adds backpressure, signed/unsigned mode, configurable size and beat width, and repeatable operation without reset.

Parameters:
- DATA_W, 8: operand element width in bits.
- N, 4: matrix dimension (N≥2).
- LANES, 4: elements per stream beat. N % LANES must be 0 (elaboration-time check).
- ACC_W, 2*DATA_W+$clog2(N): result element width. Guarantees no overflow in either mode.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block accepts an input beat.
- in_data, in, LANES*DATA_W: lane 0 in LSBs = lowest column index.
- signed_mode, in, 1: 1 = two's-complement operands. Sampled on first A beat.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts the beat.
- out_data, out, LANES*ACC_W: lane 0 in LSBs = lowest column index.
- busy, out, 1: high in COMPUTE and DRAIN.
- done, out, 1: one-cycle pulse when the last C beat is accepted.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, done=0. State = LOAD_A, all counters 0. Operand/result storage is not cleared.
- Transfer rule: a beat transfers on the rising edge where valid && ready.
- FSM states and transitions:
  - LOAD_A: accepts N*N/LANES beats of A, row-major. After the last A beat → LOAD_B.
  - LOAD_B: accepts the same count of B beats, row-major. After the last B beat → COMPUTE.
  - COMPUTE: in_ready=0.
  - DRAIN: in_ready=0.
- signed_mode capture: latched on the first A beat accepted. Held until the next matrix; changes on the pin mid-operation are ignored.
- COMPUTE timing:
  - If the last B beat is accepted at edge t, COMPUTE occupies exactly cycles t+1 … t+N*N.
  - Counters: row i (outer), k (inner).
  - Each cycle, lane j computes acc[j] ← acc[j] + ext(A[i][k])·ext(B[k][j]).
  - ext = sign- or zero-extend to ACC_W.
  - At k=N-1: acc+product is written to C[i][j], acc clears to 0, i increments.
- DRAIN:
  - out_valid=1 from cycle t+N*N+1.
  - C is streamed row-major, LANES elements per beat, N*N/LANES beats.
  - out_data/out_valid hold stable while out_valid && !out_ready.
  - No bubbles while out_ready=1.
- Completion: on the last accepted C beat, done=1 for one cycle, out_valid=0 next cycle, state → LOAD_A, in_ready=1.
- Back-to-back operation: the next matrix load may begin the cycle after done.
- Arithmetic:
  - Unsigned results are exact in ACC_W.
  - Signed results are exact two's complement in ACC_W. Worst case N·(−2^(DATA_W−1))² fits.
- Input during non-load states: in_valid high in COMPUTE/DRAIN is ignored; no data is consumed.
- Input gaps: in_valid may drop between beats in LOAD states; the counters hold.
- Reset mid-operation (any state): return to reset values on the next edge. Partial loads and results are discarded, and no done pulse is issued.
- Simultaneous events: reset has priority over any concurrent transfer.

Decomposition:
- Package matrix_mult_pkg:
  - state enum {LOAD_A, LOAD_B, COMPUTE, DRAIN}.
  - function acc_width(DATA_W, N).
  - beat-count constant helpers.
- Sub-module mac_lane (one per column j, N instances). Ports: clk, reset, clear, en, signed_mode, a, b, acc_out.
  - Registered accumulator; clear loads the product rather than adding.

Test Plan:
- Identity (N=4, LANES=4, unsigned): A=I, B[r][c]=4r+c → C beats equal B rows {0,1,2,3}, {4..7}, …. First out_valid exactly 16 cycles after the last B beat; done pulses once.
- Unsigned max: A=B=all 255 → every C element = 260100 (ACC_W=18), no wrap.
- Signed extremes: signed_mode=1, A=B=all −128 → every C = 65536. A=all −128, B=all 127 → every C = −65024. Toggling signed_mode after the first A beat has no effect.
- Backpressure and gaps:
  - Random in_valid gaps → the same C as a gapless run.
  - out_ready low for 5 cycles mid-drain → out_data frozen, no beat lost or duplicated, done still occurs after exactly 4 accepted beats.
- Reset mid-COMPUTE:
  - Assert reset at cycle t+7 → next cycle in_ready=1, out_valid=0, busy=0, no done.
  - A fresh A=I, B=2I run → C=2I.
- Alternate parameters and back-to-back: N=2, LANES=1, A=[[1,2],[3,4]], B=[[5,6],[7,8]] → out beats 19, 22, 43, 50. A second matrix loaded immediately after done computes correctly.
